// File: rtl/axi_io_pmp_err_slv_pkg.sv
// Shared definitions for the IO-PMP deny-leg AXI responder:
// AXI response codes and the state encodings of the write and read FSMs.
package axi_io_pmp_pkg;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Write path: wait for AW, swallow W beats, return one B
  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_DATA = 2'd1,
    WR_RESP = 2'd2
  } wr_state_e;

  // Read path: wait for AR, emit arlen+1 R beats
  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_e;

  // A burst beat is the final one when its index equals the AXI length field
  function automatic logic beat_is_last(input logic [7:0] count, input logic [7:0] len);
    return (count == len);
  endfunction

  // Only error codes make sense for a responder that terminates denied traffic
  function automatic logic resp_is_error(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi_io_pmp_err_slv.sv
// AXI4 terminating responder for the IO-PMP deny leg.
// Every write is completed with a single B and every read with exactly
// arlen+1 R beats, all carrying the configured error response, so blocked
// initiators never hang. One write and one read may be outstanding at a time
// and the two paths are fully independent.
//
// Handshake rule on every channel: a transfer happens on the rising clock
// edge where valid and ready are both high; a source holding valid high keeps
// its payload stable until that edge, and ready may toggle freely.
//
// All outputs come straight from flops; each FSM computes next-state and
// next-output values in one always_comb and registers them in one always_ff.
module axi_io_pmp_err_slv
  import axi_io_pmp_pkg::*;
#(
  parameter int          DATA_WIDTH    = 32,
  parameter int          ADDR_WIDTH    = 32,
  parameter int          STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int          ID_WIDTH      = 8,
  parameter int          BUSER_WIDTH   = 1,
  parameter int          RUSER_WIDTH   = 1,
  parameter logic [1:0]  RESP          = RESP_DECERR,
  parameter logic [31:0] RDATA_PATTERN = 32'hDEADBEEF
) (
  input  logic                   clk,
  input  logic                   rst,
  // write address
  input  logic [ID_WIDTH-1:0]    s_axi_awid,
  input  logic [7:0]             s_axi_awlen,
  input  logic                   s_axi_awvalid,
  output logic                   s_axi_awready,
  // write data
  input  logic                   s_axi_wlast,
  input  logic                   s_axi_wvalid,
  output logic                   s_axi_wready,
  // write response
  output logic [ID_WIDTH-1:0]    s_axi_bid,
  output logic [1:0]             s_axi_bresp,
  output logic [BUSER_WIDTH-1:0] s_axi_buser,
  output logic                   s_axi_bvalid,
  input  logic                   s_axi_bready,
  // read address
  input  logic [ID_WIDTH-1:0]    s_axi_arid,
  input  logic [7:0]             s_axi_arlen,
  input  logic                   s_axi_arvalid,
  output logic                   s_axi_arready,
  // read data
  output logic [ID_WIDTH-1:0]    s_axi_rid,
  output logic [DATA_WIDTH-1:0]  s_axi_rdata,
  output logic [1:0]             s_axi_rresp,
  output logic                   s_axi_rlast,
  output logic [RUSER_WIDTH-1:0] s_axi_ruser,
  output logic                   s_axi_rvalid,
  input  logic                   s_axi_rready,
  // protocol monitor
  output logic                   wlast_err
);

  // Read data pattern, zero-extended or truncated to the bus width
  localparam logic [DATA_WIDTH-1:0] RDATA_FIT = DATA_WIDTH'(RDATA_PATTERN);

  // Reject configurations that cannot describe a legal AXI port or that
  // would answer denied traffic with a success code.
  if (STRB_WIDTH != DATA_WIDTH / 8 || ADDR_WIDTH < 1 || !resp_is_error(RESP)) begin : g_bad_cfg
    $error("axi_io_pmp_err_slv: inconsistent widths or non-error RESP");
  end

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  wr_state_e           wr_state, wr_state_n;
  logic                awready_r, awready_n;
  logic                wready_r, wready_n;
  logic                bvalid_r, bvalid_n;
  logic [ID_WIDTH-1:0] bid_r, bid_n;
  logic [7:0]          wcnt_r, wcnt_n;
  logic [7:0]          wlen_r, wlen_n;
  logic                wlast_err_r, wlast_err_n;

  // Write FSM: next state and next registered outputs
  always_comb begin
    wr_state_n  = wr_state;
    awready_n   = awready_r;
    wready_n    = wready_r;
    bvalid_n    = bvalid_r;
    bid_n       = bid_r;
    wcnt_n      = wcnt_r;
    wlen_n      = wlen_r;
    wlast_err_n = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        // awready rises one cycle after reset or after a B handshake;
        // W beats are stalled until an AW has been accepted.
        awready_n = 1'b1;
        wready_n  = 1'b0;
        bvalid_n  = 1'b0;
        if (s_axi_awvalid && awready_r) begin
          wr_state_n = WR_DATA;
          awready_n  = 1'b0;
          wready_n   = 1'b1;
          bid_n      = s_axi_awid;
          wlen_n     = s_axi_awlen;
          wcnt_n     = 8'd0;
        end
      end
      WR_DATA: begin
        if (s_axi_wvalid && wready_r) begin
          // wlast is only monitored; the beat count alone ends the burst
          wlast_err_n = (s_axi_wlast != beat_is_last(wcnt_r, wlen_r));
          if (beat_is_last(wcnt_r, wlen_r)) begin
            wr_state_n = WR_RESP;
            wready_n   = 1'b0;
            bvalid_n   = 1'b1;
          end else begin
            wcnt_n = wcnt_r + 8'd1;
          end
        end
      end
      WR_RESP: begin
        // bid was latched at AW time and holds until the B handshake
        if (s_axi_bready && bvalid_r) begin
          wr_state_n = WR_IDLE;
          bvalid_n   = 1'b0;
          awready_n  = 1'b1;
        end
      end
      default: begin
        wr_state_n = WR_IDLE;
        awready_n  = 1'b0;
        wready_n   = 1'b0;
        bvalid_n   = 1'b0;
      end
    endcase
  end

  // Write FSM: state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state    <= WR_IDLE;
      awready_r   <= 1'b0;
      wready_r    <= 1'b0;
      bvalid_r    <= 1'b0;
      bid_r       <= '0;
      wcnt_r      <= 8'd0;
      wlen_r      <= 8'd0;
      wlast_err_r <= 1'b0;
    end else begin
      wr_state    <= wr_state_n;
      awready_r   <= awready_n;
      wready_r    <= wready_n;
      bvalid_r    <= bvalid_n;
      bid_r       <= bid_n;
      wcnt_r      <= wcnt_n;
      wlen_r      <= wlen_n;
      wlast_err_r <= wlast_err_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  rd_state_e           rd_state, rd_state_n;
  logic                arready_r, arready_n;
  logic                rvalid_r, rvalid_n;
  logic [ID_WIDTH-1:0] rid_r, rid_n;
  logic                rlast_r, rlast_n;
  logic [7:0]          rcnt_r, rcnt_n;
  logic [7:0]          rlen_r, rlen_n;

  // Read FSM: next state and next registered outputs
  always_comb begin
    rd_state_n = rd_state;
    arready_n  = arready_r;
    rvalid_n   = rvalid_r;
    rid_n      = rid_r;
    rlast_n    = rlast_r;
    rcnt_n     = rcnt_r;
    rlen_n     = rlen_r;
    case (rd_state)
      RD_IDLE: begin
        arready_n = 1'b1;
        rvalid_n  = 1'b0;
        rlast_n   = 1'b0;
        if (s_axi_arvalid && arready_r) begin
          rd_state_n = RD_DATA;
          arready_n  = 1'b0;
          rvalid_n   = 1'b1;
          rid_n      = s_axi_arid;
          rlen_n     = s_axi_arlen;
          rcnt_n     = 8'd0;
          rlast_n    = beat_is_last(8'd0, s_axi_arlen);
        end
      end
      RD_DATA: begin
        // Payload only moves on a handshake, so it is stable across stalls.
        // The counter stops at arlen, so arlen=255 never wraps.
        if (s_axi_rready && rvalid_r) begin
          if (rlast_r) begin
            rd_state_n = RD_IDLE;
            rvalid_n   = 1'b0;
            rlast_n    = 1'b0;
            arready_n  = 1'b1;
          end else begin
            rcnt_n  = rcnt_r + 8'd1;
            rlast_n = beat_is_last(rcnt_r + 8'd1, rlen_r);
          end
        end
      end
      default: begin
        rd_state_n = RD_IDLE;
        arready_n  = 1'b0;
        rvalid_n   = 1'b0;
        rlast_n    = 1'b0;
      end
    endcase
  end

  // Read FSM: state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state  <= RD_IDLE;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rid_r     <= '0;
      rlast_r   <= 1'b0;
      rcnt_r    <= 8'd0;
      rlen_r    <= 8'd0;
    end else begin
      rd_state  <= rd_state_n;
      arready_r <= arready_n;
      rvalid_r  <= rvalid_n;
      rid_r     <= rid_n;
      rlast_r   <= rlast_n;
      rcnt_r    <= rcnt_n;
      rlen_r    <= rlen_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign s_axi_awready = awready_r;
  assign s_axi_wready  = wready_r;
  assign s_axi_bid     = bid_r;
  assign s_axi_bresp   = RESP;
  assign s_axi_buser   = '0;
  assign s_axi_bvalid  = bvalid_r;

  assign s_axi_arready = arready_r;
  assign s_axi_rid     = rid_r;
  assign s_axi_rdata   = RDATA_FIT;
  assign s_axi_rresp   = RESP;
  assign s_axi_rlast   = rlast_r;
  assign s_axi_ruser   = '0;
  assign s_axi_rvalid  = rvalid_r;

  assign wlast_err     = wlast_err_r;

endmodule

// File: tb/tb_axi_io_pmp_err_slv.sv
// Testbench for axi_io_pmp_err_slv: directed steps plus randomized bursts,
// checked against a transaction-level reference model (expected R beat queue,
// expected wlast error count, expected B contents).
module tb_axi_io_pmp_err_slv;

  localparam int ID_W = 8;
  localparam int DW   = 32;
  localparam int W    = ID_W + 1 + DW + 2 + 1; // {rid, rlast, rdata, rresp, ruser}

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [ID_W-1:0] s_axi_awid;
  logic [7:0]      s_axi_awlen;
  logic            s_axi_awvalid, s_axi_awready;
  logic            s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic [ID_W-1:0] s_axi_bid;
  logic [1:0]      s_axi_bresp;
  logic [0:0]      s_axi_buser;
  logic            s_axi_bvalid, s_axi_bready;
  logic [ID_W-1:0] s_axi_arid;
  logic [7:0]      s_axi_arlen;
  logic            s_axi_arvalid, s_axi_arready;
  logic [ID_W-1:0] s_axi_rid;
  logic [DW-1:0]   s_axi_rdata;
  logic [1:0]      s_axi_rresp;
  logic            s_axi_rlast;
  logic [0:0]      s_axi_ruser;
  logic            s_axi_rvalid, s_axi_rready;
  logic            wlast_err;

  axi_io_pmp_err_slv dut (
    .clk           (clk),
    .rst           (rst),
    .s_axi_awid    (s_axi_awid),
    .s_axi_awlen   (s_axi_awlen),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wlast   (s_axi_wlast),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bid     (s_axi_bid),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_buser   (s_axi_buser),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_arid    (s_axi_arid),
    .s_axi_arlen   (s_axi_arlen),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rid     (s_axi_rid),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rlast   (s_axi_rlast),
    .s_axi_ruser   (s_axi_ruser),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .wlast_err     (wlast_err)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int tests_run    = 0;
  int tests_failed = 0;
  int werr_cnt     = 0;
  int wbeat_cnt    = 0;
  int rbeat_cnt    = 0;
  logic [W-1:0] exp_q[$];
  logic         stall_prev = 1'b0;
  logic [W:0]   prev_word  = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model for one read burst: arlen+1 beats, last flagged on index arlen
  task automatic push_read(input logic [ID_W-1:0] id, input int len);
    for (int i = 0; i <= len; i++)
      exp_q.push_back({id, (i == len), 32'hDEADBEEF, 2'b11, 1'b0});
  endtask

  // R channel monitor, sampled mid-cycle while inputs are stable
  always @(negedge clk) begin
    logic [W:0] cur;
    cur = {s_axi_rvalid, s_axi_rid, s_axi_rlast, s_axi_rdata, s_axi_rresp, s_axi_ruser};
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) check("r_stall_stable", 64'(cur), 64'(prev_word));
      if (s_axi_rvalid && s_axi_rready) begin
        rbeat_cnt++;
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $error("FAIL r_unexpected_beat: observed beat %0h expected none", cur);
        end else begin
          check("r_beat", 64'(cur[W-1:0]), 64'(exp_q.pop_front()));
        end
      end
      stall_prev = s_axi_rvalid && !s_axi_rready;
      prev_word  = cur;
      if (s_axi_wvalid && s_axi_wready) wbeat_cnt++;
      if (wlast_err) werr_cnt++;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // wlast_mask bit i is the wlast value driven on beat i
  task automatic do_write(input logic [ID_W-1:0] id, input int len,
                          input logic [255:0] wlast_mask, input int bhold, input bit rand_w);
    int n;
    int i;
    int exp_err;
    int werr0;
    int wb0;
    bit hs;
    exp_err = 0;
    for (int k = 0; k <= len; k++)
      if (wlast_mask[k] != (k == len)) exp_err++;
    werr0 = werr_cnt;
    wb0   = wbeat_cnt;

    s_axi_awid    = id;
    s_axi_awlen   = 8'(len);
    s_axi_awvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 50) begin step(); n++; end
    check("aw_ready_seen", 64'(s_axi_awready), 64'd1);
    step();
    s_axi_awvalid = 1'b0;

    i = 0;
    n = 0;
    while (i <= len && n < 2000) begin
      s_axi_wvalid = rand_w ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_axi_wlast  = wlast_mask[i];
      hs = s_axi_wvalid && s_axi_wready;
      step();
      if (hs) i++;
      n++;
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
    check("w_all_beats_sent", 64'(i), 64'(len + 1));

    n = 0;
    while (!s_axi_bvalid && n < 20) begin step(); n++; end
    check("b_valid_seen", 64'(s_axi_bvalid), 64'd1);
    for (int h = 0; h < bhold; h++) begin
      step();
      check("b_hold_valid", 64'(s_axi_bvalid), 64'd1);
      check("b_hold_id", 64'(s_axi_bid), 64'(id));
    end
    check("b_id", 64'(s_axi_bid), 64'(id));
    check("b_resp", 64'(s_axi_bresp), 64'd3);
    check("b_user", 64'(s_axi_buser), 64'd0);
    s_axi_bready = 1'b1;
    step();
    s_axi_bready = 1'b0;
    check("b_valid_drop", 64'(s_axi_bvalid), 64'd0);
    check("aw_ready_after_b", 64'(s_axi_awready), 64'd1);
    check("w_beats_accepted", 64'(wbeat_cnt - wb0), 64'(len + 1));
    check("wlast_err_pulses", 64'(werr_cnt - werr0), 64'(exp_err));
  endtask

  // mode 0: rready held high, 1: toggles 1-0-1, 2: random
  task automatic do_read(input logic [ID_W-1:0] id, input int len, input int mode);
    int n;
    int rb0;
    rb0 = rbeat_cnt;
    push_read(id, len);
    s_axi_arid    = id;
    s_axi_arlen   = 8'(len);
    s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 50) begin step(); n++; end
    check("ar_ready_seen", 64'(s_axi_arready), 64'd1);
    step();
    s_axi_arvalid = 1'b0;
    check("r_valid_after_ar", 64'(s_axi_rvalid), 64'd1);
    check("ar_ready_busy", 64'(s_axi_arready), 64'd0);

    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      case (mode)
        0:       s_axi_rready = 1'b1;
        1:       s_axi_rready = (n % 2 == 0);
        default: s_axi_rready = 1'($urandom_range(0, 1));
      endcase
      step();
      n++;
    end
    s_axi_rready = 1'b0;
    check("r_drained", 64'(exp_q.size()), 64'd0);
    check("r_beat_count", 64'(rbeat_cnt - rb0), 64'(len + 1));
    check("r_valid_done", 64'(s_axi_rvalid), 64'd0);
    check("ar_ready_done", 64'(s_axi_arready), 64'd1);
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Directed and randomized sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [255:0] mask;
    int len;
    int wb0;
    int rb0;

    rst           = 1'b1;
    s_axi_awid    = '0;
    s_axi_awlen   = '0;
    s_axi_awvalid = 1'b0;
    s_axi_wlast   = 1'b0;
    s_axi_wvalid  = 1'b0;
    s_axi_bready  = 1'b0;
    s_axi_arid    = '0;
    s_axi_arlen   = '0;
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b0;

    // Reset values and release
    repeat (3) step();
    check("rst_awready", 64'(s_axi_awready), 64'd0);
    check("rst_arready", 64'(s_axi_arready), 64'd0);
    check("rst_bvalid", 64'(s_axi_bvalid), 64'd0);
    check("rst_rvalid", 64'(s_axi_rvalid), 64'd0);
    check("rst_wready", 64'(s_axi_wready), 64'd0);
    check("rst_wlast_err", 64'(wlast_err), 64'd0);
    check("rst_bid", 64'(s_axi_bid), 64'd0);
    check("rst_rid", 64'(s_axi_rid), 64'd0);
    check("rst_rlast", 64'(s_axi_rlast), 64'd0);
    rst = 1'b0;
    step();
    check("rel_awready", 64'(s_axi_awready), 64'd1);
    check("rel_arready", 64'(s_axi_arready), 64'd1);
    check("rel_bvalid", 64'(s_axi_bvalid), 64'd0);
    check("rel_rvalid", 64'(s_axi_rvalid), 64'd0);

    // W before AW is stalled
    wb0 = wbeat_cnt;
    s_axi_wvalid = 1'b1;
    s_axi_wlast  = 1'b1;
    repeat (3) begin
      step();
      check("w_early_stalled", 64'(s_axi_wready), 64'd0);
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
    check("w_early_no_beats", 64'(wbeat_cnt - wb0), 64'd0);

    // Write awid=0x5A awlen=3, correct wlast, bready immediately
    mask = '0;
    mask[3] = 1'b1;
    do_write(8'h5A, 3, mask, 0, 1'b0);

    // Read arid=0x11 arlen=255 with rready toggling
    do_read(8'h11, 255, 1);

    // Write awlen=1, wlast already on beat 0 (and on beat 1): one bad beat
    mask = '0;
    mask[0] = 1'b1;
    mask[1] = 1'b1;
    do_write(8'hC3, 1, mask, 2, 1'b0);

    // Write awlen=1, wlast only on beat 0: both beats disagree
    mask = '0;
    mask[0] = 1'b1;
    do_write(8'h3C, 1, mask, 0, 1'b0);

    // Simultaneous AW and AR, both length 0, responses held off 5 cycles
    push_read(8'h33, 0);
    s_axi_awid    = 8'h77;
    s_axi_awlen   = 8'd0;
    s_axi_awvalid = 1'b1;
    s_axi_arid    = 8'h33;
    s_axi_arlen   = 8'd0;
    s_axi_arvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    s_axi_wlast   = 1'b1;
    step();
    s_axi_awvalid = 1'b0;
    s_axi_arvalid = 1'b0;
    check("sim_awready_low", 64'(s_axi_awready), 64'd0);
    check("sim_wready_high", 64'(s_axi_wready), 64'd1);
    check("sim_arready_low", 64'(s_axi_arready), 64'd0);
    check("sim_rvalid", 64'(s_axi_rvalid), 64'd1);
    check("sim_rid", 64'(s_axi_rid), 64'h33);
    check("sim_rlast", 64'(s_axi_rlast), 64'd1);
    step();
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
    check("sim_b_latency2", 64'(s_axi_bvalid), 64'd1);
    for (int h = 0; h < 5; h++) begin
      step();
      check("sim_hold_bvalid", 64'(s_axi_bvalid), 64'd1);
      check("sim_hold_bid", 64'(s_axi_bid), 64'h77);
      check("sim_hold_rvalid", 64'(s_axi_rvalid), 64'd1);
      check("sim_hold_rid", 64'(s_axi_rid), 64'h33);
    end
    s_axi_bready = 1'b1;
    s_axi_rready = 1'b1;
    step();
    s_axi_bready = 1'b0;
    s_axi_rready = 1'b0;
    check("sim_bvalid_done", 64'(s_axi_bvalid), 64'd0);
    check("sim_rvalid_done", 64'(s_axi_rvalid), 64'd0);
    check("sim_awready_back", 64'(s_axi_awready), 64'd1);
    check("sim_arready_back", 64'(s_axi_arready), 64'd1);
    check("sim_r_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();

    // Reset in the middle of an arlen=7 read, at beat 2
    push_read(8'h9E, 7);
    s_axi_arid    = 8'h9E;
    s_axi_arlen   = 8'd7;
    s_axi_arvalid = 1'b1;
    step();
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b1;
    step();
    step();
    check("mid_beats_done", 64'(exp_q.size()), 64'd6);
    check("mid_rvalid_before", 64'(s_axi_rvalid), 64'd1);
    rst = 1'b1;
    step();
    check("mid_rst_rvalid", 64'(s_axi_rvalid), 64'd0);
    check("mid_rst_arready", 64'(s_axi_arready), 64'd0);
    exp_q.delete();
    rb0 = rbeat_cnt;
    rst = 1'b0;
    step();
    check("mid_rel_arready", 64'(s_axi_arready), 64'd1);
    check("mid_rel_rvalid", 64'(s_axi_rvalid), 64'd0);
    repeat (4) begin
      step();
      check("mid_no_stray", 64'(s_axi_rvalid), 64'd0);
    end
    s_axi_rready = 1'b0;
    check("mid_no_stray_beats", 64'(rbeat_cnt - rb0), 64'd0);

    // Randomized writes and reads
    for (int t = 0; t < 8; t++) begin
      len  = $urandom_range(0, 12);
      mask = '0;
      mask[len] = 1'b1;
      if ($urandom_range(0, 1) == 1) mask[$urandom_range(0, len)] ^= 1'b1;
      do_write(8'($urandom), len, mask, $urandom_range(0, 3), 1'b1);
      do_read(8'($urandom), $urandom_range(0, 20), 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time limit
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", tests_run);
    $fatal(1, "time limit reached");
  end

endmodule
